// File: rtl/alu_sequencer_if.sv
// Command/response bundle for alu_sequencer: command handshake in,
// result handshake out, plus status.
interface alu_sequencer_if #(
    parameter int WIDTH = 24
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_r;
    logic             busy;
    logic [15:0]      op_count;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_r, busy, op_count
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_r, busy, op_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// Single-command ALU sequencer: ADD/AND in one RUN cycle, shifts one bit per
// cycle with the amount clamped to WIDTH, result held in DONE until taken.
module alu_sequencer #(
    parameter int WIDTH = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_AND, OP_SHR, OP_SHL} op_t;

    state_t           state, state_nx;
    op_t              op;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b;
    logic [CW-1:0]    cnt;
    logic [15:0]      op_count;
    logic             accept;
    logic             rsp_hs;
    logic             is_shift;

    assign accept   = bus.cmd_valid & bus.cmd_ready;
    assign rsp_hs   = bus.rsp_valid & bus.rsp_ready;
    assign is_shift = (op == OP_SHR) || (op == OP_SHL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (!is_shift || cnt == '0) state_nx = DONE;
            DONE:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // cmd_ready is gated by rst_n so it stays low for the whole reset pulse.
    always_comb begin
        bus.cmd_ready = rst_n && (state == IDLE);
        bus.rsp_valid = (state == DONE);
        bus.rsp_r     = (state == DONE) ? acc : '0;
        bus.busy      = (state != IDLE);
        bus.op_count  = op_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op  <= OP_ADD;
            acc <= '0;
            b   <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op  <= op_t'(bus.cmd_op);
                    acc <= bus.cmd_a;
                    b   <= bus.cmd_b;
                    // any amount >= WIDTH shifts everything out
                    cnt <= (bus.cmd_b >= WIDTH'(WIDTH)) ? CW'(WIDTH) : bus.cmd_b[CW-1:0];
                end
                RUN: begin
                    case (op)
                        OP_ADD: acc <= acc + b;
                        OP_AND: acc <= acc & b;
                        OP_SHR: if (cnt != '0) begin
                            acc <= acc >> 1;
                            cnt <= cnt - 1'b1;
                        end
                        OP_SHL: if (cnt != '0) begin
                            acc <= acc << 1;
                            cnt <= cnt - 1'b1;
                        end
                        default: acc <= acc;
                    endcase
                end
                default: acc <= acc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      op_count <= '0;
        else if (rsp_hs) op_count <= op_count + 16'd1;
    end
endmodule
